// File: rtl/ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker
//
// Receives raw PS/2 keyboard frames and turns the make/break/extended scan
// code stream into a small "held keys" state: up to two movement keys plus
// dedicated shoot and jump flags. Everything runs on Clk; psClk/psData are
// asynchronous and are synchronised here.
//
// Ports
//   Clk       in   system clock (50 MHz)
//   Reset     in   asynchronous, active-low reset
//   psClk     in   PS/2 clock pin (asynchronous)
//   psData    in   PS/2 data pin (asynchronous)
//   key1      out  first held movement key make code, 8'h00 when empty
//   key2      out  second held movement key make code, 8'h00 when empty
//   keyCount  out  number of held movement keys (0..2)
//   Shooting  out  shoot key held
//   Jumping   out  jump key held
//   press     out  any movement key, shoot or jump held (registered)
//   frameErr  out  one-cycle pulse on parity, stop-bit or timeout error
// ---------------------------------------------------------------------------
module ps2_key_tracker #(
  parameter logic [7:0] KEY_SHOOT      = 8'h3B,
  parameter logic [7:0] KEY_JUMP       = 8'h29,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       psClk,
  input  logic       psData,
  output logic [7:0] key1,
  output logic [7:0] key2,
  output logic [2:0] keyCount,
  output logic       Shooting,
  output logic       Jumping,
  output logic       press,
  output logic       frameErr
);

  localparam int            TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Stage p0: two-flop synchronisers plus a third flop on the clock line
  // -------------------------------------------------------------------------
  logic r_clk_s1_p0, r_clk_s2_p0, r_clk_prev_p0;
  logic r_dat_s1_p0, r_dat_s2_p0;
  logic w_fall_p0;

  // Flops reset to the idle-high line level so release of reset never
  // fabricates a falling edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_clk_s1_p0   <= 1'b1;
      r_clk_s2_p0   <= 1'b1;
      r_clk_prev_p0 <= 1'b1;
      r_dat_s1_p0   <= 1'b1;
      r_dat_s2_p0   <= 1'b1;
    end else begin
      r_clk_s1_p0   <= psClk;
      r_clk_s2_p0   <= r_clk_s1_p0;
      r_clk_prev_p0 <= r_clk_s2_p0;
      r_dat_s1_p0   <= psData;
      r_dat_s2_p0   <= r_dat_s1_p0;
    end
  end

  assign w_fall_p0 = r_clk_prev_p0 & ~r_clk_s2_p0;

  // -------------------------------------------------------------------------
  // Stage p1: registered falling-edge strobe with its data sample
  // -------------------------------------------------------------------------
  logic r_fall_p1;
  logic r_dat_p1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fall_p1 <= 1'b0;
      r_dat_p1  <= 1'b1;
    end else begin
      r_fall_p1 <= w_fall_p0;
      r_dat_p1  <= r_dat_s2_p0;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p2: frame receive FSM, produces byte-valid / frame-error strobes
  // -------------------------------------------------------------------------
  state_t          r_state, w_state_nxt;
  logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [TW-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_parity, w_parity_nxt;
  logic            r_byte_vld_p2, w_byte_vld_nxt;
  logic            r_err_p2, w_err_nxt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd0;
      r_to_cnt      <= '0;
      r_byte_vld_p2 <= 1'b0;
      r_err_p2      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_byte_vld_p2 <= w_byte_vld_nxt;
      r_err_p2      <= w_err_nxt;
    end
  end

  // Shift register and parity bit are pure data; their content is only
  // looked at while the FSM qualifies it, so they carry no reset.
  always_ff @(posedge Clk) begin
    r_shift  <= w_shift_nxt;
    r_parity <= w_parity_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_parity_nxt   = r_parity;
    w_byte_vld_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    w_to_cnt_nxt   = r_to_cnt + 1'b1;

    if ((r_state == ST_IDLE) || r_fall_p1) begin
      w_to_cnt_nxt = '0;
    end

    case (r_state)
      ST_IDLE: begin
        if (r_fall_p1 && !r_dat_p1) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      ST_DATA: begin
        if (r_fall_p1) begin
          w_shift_nxt   = {r_dat_p1, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (r_fall_p1) begin
          w_parity_nxt = r_dat_p1;
          w_state_nxt  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_fall_p1) begin
          // Odd parity: data bits plus parity bit must XOR to 1.
          if (r_dat_p1 && (^{r_shift, r_parity})) begin
            w_byte_vld_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A stalled PS/2 clock abandons the partial frame. A falling edge in the
    // same cycle wins because it restarts the inactivity window.
    if ((r_state != ST_IDLE) && !r_fall_p1 && (r_to_cnt == TO_LAST)) begin
      w_state_nxt  = ST_IDLE;
      w_err_nxt    = 1'b1;
      w_to_cnt_nxt = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p3: scan-code decoder and held-key table
  // -------------------------------------------------------------------------
  logic       r_ext, w_ext_nxt;
  logic       r_brk, w_brk_nxt;
  logic [7:0] r_key1_p3, w_key1_nxt;
  logic [7:0] r_key2_p3, w_key2_nxt;
  logic [2:0] r_count_p3, w_count_nxt;
  logic       r_shoot_p3, w_shoot_nxt;
  logic       r_jump_p3, w_jump_nxt;
  logic       r_press_p3, w_press_nxt;
  logic       w_in_table;

  // Empty slots hold 8'h00 and code 8'h00 is never stored, so a plain
  // compare against both slots is enough once the count is qualified.
  assign w_in_table = ((r_count_p3 != 3'd0) && (r_shift == r_key1_p3)) ||
                      ((r_count_p3 == 3'd2) && (r_shift == r_key2_p3));

  always_comb begin
    w_ext_nxt   = r_ext;
    w_brk_nxt   = r_brk;
    w_key1_nxt  = r_key1_p3;
    w_key2_nxt  = r_key2_p3;
    w_count_nxt = r_count_p3;
    w_shoot_nxt = r_shoot_p3;
    w_jump_nxt  = r_jump_p3;

    if (r_byte_vld_p2) begin
      if (r_shift == CODE_EXT) begin
        w_ext_nxt = 1'b1;
      end else if (r_shift == CODE_BRK) begin
        w_brk_nxt = 1'b1;
      end else begin
        w_ext_nxt = 1'b0;
        w_brk_nxt = 1'b0;
        // Extended codes only clear the prefix flags. Code 00 (keyboard
        // overrun) is dropped so an empty slot can never look held.
        if (!r_ext && (r_shift != 8'h00)) begin
          if (!r_brk) begin
            if (r_shift == KEY_SHOOT) begin
              w_shoot_nxt = 1'b1;
            end else if (r_shift == KEY_JUMP) begin
              w_jump_nxt = 1'b1;
            end else if (!w_in_table) begin
              if (r_count_p3 == 3'd0) begin
                w_key1_nxt  = r_shift;
                w_count_nxt = 3'd1;
              end else if (r_count_p3 == 3'd1) begin
                w_key2_nxt  = r_shift;
                w_count_nxt = 3'd2;
              end
            end
          end else begin
            if (r_shift == KEY_SHOOT) begin
              w_shoot_nxt = 1'b0;
            end else if (r_shift == KEY_JUMP) begin
              w_jump_nxt = 1'b0;
            end else if ((r_count_p3 != 3'd0) && (r_shift == r_key1_p3)) begin
              // Releasing the first key promotes the second one.
              w_key1_nxt  = r_key2_p3;
              w_key2_nxt  = 8'h00;
              w_count_nxt = r_count_p3 - 3'd1;
            end else if ((r_count_p3 == 3'd2) && (r_shift == r_key2_p3)) begin
              w_key2_nxt  = 8'h00;
              w_count_nxt = 3'd1;
            end
          end
        end
      end
    end

    w_press_nxt = (w_count_nxt != 3'd0) | w_shoot_nxt | w_jump_nxt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_key1_p3  <= 8'h00;
      r_key2_p3  <= 8'h00;
      r_count_p3 <= 3'd0;
      r_shoot_p3 <= 1'b0;
      r_jump_p3  <= 1'b0;
      r_press_p3 <= 1'b0;
    end else begin
      r_ext      <= w_ext_nxt;
      r_brk      <= w_brk_nxt;
      r_key1_p3  <= w_key1_nxt;
      r_key2_p3  <= w_key2_nxt;
      r_count_p3 <= w_count_nxt;
      r_shoot_p3 <= w_shoot_nxt;
      r_jump_p3  <= w_jump_nxt;
      r_press_p3 <= w_press_nxt;
    end
  end

  assign key1     = r_key1_p3;
  assign key2     = r_key2_p3;
  assign keyCount = r_count_p3;
  assign Shooting = r_shoot_p3;
  assign Jumping  = r_jump_p3;
  assign press    = r_press_p3;
  assign frameErr = r_err_p2;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_tracker
//
// Drives PS/2 frames into ps2_key_tracker: a latency sequence, a table of
// directed frames with expected outputs, hand-written timeout and reset
// sequences, then random frames checked against a queue-based key model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_key_tracker;

  localparam int TO_CYC = 2000;
  localparam int HALF   = 10;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       psClk = 1'b1;
  logic       psData = 1'b1;
  logic [7:0] key1, key2;
  logic [2:0] keyCount;
  logic       Shooting, Jumping, press, frameErr;

  ps2_key_tracker #(
    .KEY_SHOOT(8'h3B),
    .KEY_JUMP(8'h29),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .psClk(psClk),
    .psData(psData),
    .key1(key1),
    .key2(key2),
    .keyCount(keyCount),
    .Shooting(Shooting),
    .Jumping(Jumping),
    .press(press),
    .frameErr(frameErr)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int err_hi = 0;
  int err_rises = 0;
  int exp_err = 0;
  logic err_prev = 1'b0;

  always @(negedge Clk) begin
    err_prev <= frameErr;
    if (frameErr) begin
      err_hi <= err_hi + 1;
      if (!err_prev) err_rises <= err_rises + 1;
    end
  end

  typedef struct {
    logic [7:0]  code;
    logic        par_ok;
    logic        stop_b;
    logic [21:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [21:0] outs(logic [7:0] k1, logic [7:0] k2, logic [2:0] c,
                                       logic s, logic j);
    return {k1, k2, c, s, j, (c != 3'd0) | s | j};
  endfunction

  function automatic vec_t mk(logic [7:0] code, logic par_ok, logic stop_b,
                              logic [7:0] k1, logic [7:0] k2, logic [2:0] c,
                              logic s, logic j, logic err);
    vec_t v;
    v.code = code; v.par_ok = par_ok; v.stop_b = stop_b;
    v.exp = outs(k1, k2, c, s, j); v.err = err;
    return v;
  endfunction

  function automatic logic [21:0] dut_outs();
    return {key1, key2, keyCount, Shooting, Jumping, press};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge Clk);
    psData = b;
    repeat (HALF) @(negedge Clk);
    psClk = 1'b0;
    repeat (HALF) @(negedge Clk);
    psClk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_ok, input logic stop_b);
    logic par;
    par = ~(^code);
    if (!par_ok) par = ~par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(stop_b);
    @(negedge Clk);
    psData = 1'b1;
  endtask

  task automatic check_errs(input string name);
    check({name, "_err_pulses"}, err_rises, exp_err);
    check({name, "_err_width"}, err_hi, exp_err);
  endtask

  // Behavioural model for the random phase.
  logic [7:0] m_q[$];
  logic       m_ext, m_brk, m_s, m_j;

  function automatic logic [21:0] model_outs();
    logic [7:0] k1, k2;
    k1 = (m_q.size() > 0) ? m_q[0] : 8'h00;
    k2 = (m_q.size() > 1) ? m_q[1] : 8'h00;
    return outs(k1, k2, 3'(m_q.size()), m_s, m_j);
  endfunction

  task automatic model_byte(input logic [7:0] code);
    int idx;
    if (code == 8'hE0) m_ext = 1'b1;
    else if (code == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext) begin
        if (!m_brk) begin
          if (code == 8'h3B) m_s = 1'b1;
          else if (code == 8'h29) m_j = 1'b1;
          else begin
            idx = -1;
            foreach (m_q[k]) if (m_q[k] == code) idx = k;
            if (idx < 0 && m_q.size() < 2) m_q.push_back(code);
          end
        end else begin
          if (code == 8'h3B) m_s = 1'b0;
          else if (code == 8'h29) m_j = 1'b0;
          else begin
            idx = -1;
            foreach (m_q[k]) if (m_q[k] == code && idx < 0) idx = k;
            if (idx >= 0) m_q.delete(idx);
          end
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  logic [7:0] pool [12] = '{8'h1D, 8'h1C, 8'h23, 8'h1B, 8'h2B, 8'h3B,
                            8'h29, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h5A};

  initial begin
    // Reset state
    #5;
    check("reset_outs", dut_outs(), 22'd0);
    check("reset_frameErr", frameErr, 1'b0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (5) @(negedge Clk);

    // Latency: make 1D, outputs change exactly at edge 4 after the stop fall
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'h1D >> i);
    send_bit(~(^8'h1D));
    @(negedge Clk);
    psData = 1'b1;
    repeat (HALF) @(negedge Clk);
    psClk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("latency_edge3", dut_outs(), 22'd0);
    @(posedge Clk);
    #1;
    check("latency_edge4", dut_outs(), outs(8'h1D, 8'h00, 3'd1, 1'b0, 1'b0));
    repeat (HALF) @(negedge Clk);
    psClk = 1'b1;
    repeat (HALF) @(negedge Clk);

    // Directed table
    vecs.push_back(mk(8'hF0, 1, 1, 8'h1D, 8'h00, 3'd1, 0, 0, 0));
    vecs.push_back(mk(8'h1D, 1, 1, 8'h00, 8'h00, 3'd0, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 1, 1, 8'h1C, 8'h00, 3'd1, 0, 0, 0));
    vecs.push_back(mk(8'h23, 1, 1, 8'h1C, 8'h23, 3'd2, 0, 0, 0));
    vecs.push_back(mk(8'h1B, 1, 1, 8'h1C, 8'h23, 3'd2, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 1, 1, 8'h1C, 8'h23, 3'd2, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 1, 1, 8'h1C, 8'h23, 3'd2, 0, 0, 0));
    vecs.push_back(mk(8'h2B, 1, 1, 8'h1C, 8'h23, 3'd2, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 1, 1, 8'h1C, 8'h23, 3'd2, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 1, 1, 8'h23, 8'h00, 3'd1, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 1, 1, 8'h23, 8'h00, 3'd1, 0, 0, 0));
    vecs.push_back(mk(8'h23, 1, 1, 8'h00, 8'h00, 3'd0, 0, 0, 0));
    vecs.push_back(mk(8'h3B, 1, 1, 8'h00, 8'h00, 3'd0, 1, 0, 0));
    vecs.push_back(mk(8'h29, 1, 1, 8'h00, 8'h00, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'hE0, 1, 1, 8'h00, 8'h00, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'h1D, 1, 1, 8'h00, 8'h00, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'hE0, 1, 1, 8'h00, 8'h00, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'hF0, 1, 1, 8'h00, 8'h00, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'h3B, 1, 1, 8'h00, 8'h00, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'hF0, 1, 1, 8'h00, 8'h00, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'h3B, 1, 1, 8'h00, 8'h00, 3'd0, 0, 1, 0));
    vecs.push_back(mk(8'hF0, 1, 1, 8'h00, 8'h00, 3'd0, 0, 1, 0));
    vecs.push_back(mk(8'h29, 1, 1, 8'h00, 8'h00, 3'd0, 0, 0, 0));
    vecs.push_back(mk(8'h1D, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0, 1));
    vecs.push_back(mk(8'h1D, 1, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1));
    vecs.push_back(mk(8'h1D, 1, 1, 8'h1D, 8'h00, 3'd1, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 1, 1, 8'h1D, 8'h00, 3'd1, 0, 0, 0));
    vecs.push_back(mk(8'h1D, 1, 1, 8'h00, 8'h00, 3'd0, 0, 0, 0));

    foreach (vecs[n]) begin
      send_frame(vecs[n].code, vecs[n].par_ok, vecs[n].stop_b);
      repeat (8) @(negedge Clk);
      if (vecs[n].err) exp_err++;
      check($sformatf("vec%0d_outs", n), dut_outs(), vecs[n].exp);
      check_errs($sformatf("vec%0d", n));
    end

    // Timeout: start bit plus four data bits, then the PS/2 clock stalls
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (TO_CYC + 100) @(negedge Clk);
    exp_err++;
    check_errs("timeout");
    check("timeout_outs", dut_outs(), 22'd0);
    send_frame(8'h1D, 1'b1, 1'b1);
    repeat (8) @(negedge Clk);
    check("after_timeout_outs", dut_outs(), outs(8'h1D, 8'h00, 3'd1, 1'b0, 1'b0));
    check_errs("after_timeout");

    // Asynchronous reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge Clk);
    Reset = 1'b0;
    #2;
    check("async_reset_outs", dut_outs(), 22'd0);
    repeat (3) @(negedge Clk);
    psData = 1'b1;
    psClk = 1'b1;
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    check("post_reset_outs", dut_outs(), 22'd0);

    // Random frames against the model
    m_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_s = 1'b0; m_j = 1'b0;
    for (int n = 0; n < 120; n++) begin
      logic [7:0] code;
      logic par_ok, stop_b;
      code   = pool[$urandom_range(0, 11)];
      par_ok = ($urandom_range(0, 9) != 0);
      stop_b = ($urandom_range(0, 14) != 0);
      send_frame(code, par_ok, stop_b);
      repeat (8) @(negedge Clk);
      if (par_ok && stop_b) model_byte(code);
      else exp_err++;
      check($sformatf("rand%0d_outs", n), dut_outs(), model_outs());
      check_errs($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
